// File: rtl/ifetch_unit.sv
// Instruction fetch stage: holds the PC, issues one imem request per instruction and presents it to decode.
// Optional macro IFETCH_PERF_CNT_EN adds fetch/stall performance counters.
module ifetch_unit #(
    parameter int                ADDR_W   = 32,
    parameter logic [ADDR_W-1:0] RESET_PC = 32'h0000_0000
) (
    input  logic              clock,
    input  logic              reset,
    output logic              imem_req,
    output logic [ADDR_W-1:0] imem_addr,
    input  logic              imem_rvalid,
    input  logic [31:0]       imem_rdata,
    input  logic              stall,
    input  logic              branch,
    input  logic              zero,
    input  logic [ADDR_W-1:0] branch_offset,
    input  logic              jump,
    output logic              inst_valid,
    output logic [31:0]       instruction,
    output logic [5:0]        opcode,
    output logic [ADDR_W-1:0] pc,
    output logic [ADDR_W-1:0] pc_plus4,
`ifdef IFETCH_PERF_CNT_EN
    output logic [31:0]       perf_fetched,
    output logic [31:0]       perf_stall_cycles,
`endif
    output logic [1:0]        fsm_state
);

    // Handshakes: imem_req is a one-cycle strobe with no back-pressure and
    // imem_rvalid is accepted only in WAIT. Decode takes the presented
    // instruction on fire = inst_valid & ~stall; while stalled it is held.
    localparam logic [1:0] ST_ISSUE = 2'd0;
    localparam logic [1:0] ST_WAIT  = 2'd1;
    localparam logic [1:0] ST_VALID = 2'd2;

    logic [1:0]        state;
    logic              fire;
    logic [ADDR_W-1:0] next_pc;
    logic [ADDR_W-1:0] jump_target;
    logic [ADDR_W-1:0] branch_target;

    assign imem_req    = (state == ST_ISSUE);
    assign imem_addr   = {pc[ADDR_W-1:2], 2'b00};
    assign inst_valid  = (state == ST_VALID);
    assign opcode      = instruction[31:26];
    assign pc_plus4    = pc + 32'd4;
    assign fire        = inst_valid & ~stall;
    assign fsm_state   = state;

    assign jump_target   = {pc_plus4[ADDR_W-1:ADDR_W-4], instruction[25:0], 2'b00};
    assign branch_target = pc_plus4 + {branch_offset[ADDR_W-3:0], 2'b00};

    // Jump outranks a taken branch when control raises both.
    always_comb begin
        next_pc = pc_plus4;
        if (jump) begin
            next_pc = jump_target;
        end else if (branch && zero) begin
            next_pc = branch_target;
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state <= ST_ISSUE;
        end else begin
            case (state)
                ST_ISSUE: state <= ST_WAIT;
                ST_WAIT:  if (imem_rvalid) state <= ST_VALID;
                ST_VALID: if (!stall) state <= ST_ISSUE;
                default:  state <= ST_ISSUE;
            endcase
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            pc          <= RESET_PC;
            instruction <= 32'd0;
        end else begin
            if (state == ST_WAIT && imem_rvalid) begin
                instruction <= imem_rdata;
            end
            if (fire) begin
                pc <= next_pc;
            end
        end
    end

`ifdef IFETCH_PERF_CNT_EN
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            perf_fetched      <= 32'd0;
            perf_stall_cycles <= 32'd0;
        end else begin
            if (fire) begin
                perf_fetched <= perf_fetched + 32'd1;
            end
            if (inst_valid && stall) begin
                perf_stall_cycles <= perf_stall_cycles + 32'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_ifetch_unit.sv
// Bench for ifetch_unit: directed fetch/branch/jump/stall/reset cases plus randomized traffic
// checked against a transaction-level PC model.
module tb_ifetch_unit;

    logic        clock;
    logic        reset;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_rvalid;
    logic [31:0] imem_rdata;
    logic        stall;
    logic        branch;
    logic        zero;
    logic [31:0] branch_offset;
    logic        jump;
    logic        inst_valid;
    logic [31:0] instruction;
    logic [5:0]  opcode;
    logic [31:0] pc;
    logic [31:0] pc_plus4;
    logic [1:0]  fsm_state;
`ifdef IFETCH_PERF_CNT_EN
    logic [31:0] perf_fetched;
    logic [31:0] perf_stall_cycles;
`endif

    int          total = 0;
    int          bad   = 0;
    logic [31:0] exp_q[$];
    int          m_fetched = 0;
    int          m_stalls  = 0;

    ifetch_unit #(.ADDR_W(32), .RESET_PC(32'h0000_0040)) dut (
        .clock         (clock),
        .reset         (reset),
        .imem_req      (imem_req),
        .imem_addr     (imem_addr),
        .imem_rvalid   (imem_rvalid),
        .imem_rdata    (imem_rdata),
        .stall         (stall),
        .branch        (branch),
        .zero          (zero),
        .branch_offset (branch_offset),
        .jump          (jump),
        .inst_valid    (inst_valid),
        .instruction   (instruction),
        .opcode        (opcode),
        .pc            (pc),
        .pc_plus4      (pc_plus4),
`ifdef IFETCH_PERF_CNT_EN
        .perf_fetched      (perf_fetched),
        .perf_stall_cycles (perf_stall_cycles),
`endif
        .fsm_state     (fsm_state)
    );

    // Clock and watchdog
    initial clock = 1'b0;
    always #5 clock = ~clock;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, got=timeout exp=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic drive_garbage_ctrl();
        branch        = 1'($urandom_range(0, 1));
        zero          = 1'($urandom_range(0, 1));
        jump          = 1'($urandom_range(0, 1));
        branch_offset = $urandom;
    endtask

    task automatic wait_req();
        int waited;
        waited = 0;
        while (imem_req !== 1'b1 && waited < 8) begin
            @(negedge clock);
            waited++;
        end
        check("req_seen", {31'd0, imem_req}, 32'd1);
    endtask

    // One full instruction: request, memory reply after lat cycles, optional stall, then fire.
    task automatic fetch_one(input int lat, input logic [31:0] word, input int nstall,
                             input logic br, input logic zr, input logic jp, input logic [31:0] off);
        logic [31:0] epc;
        logic [31:0] npc;
        wait_req();
        epc = (exp_q.size() > 0) ? exp_q.pop_front() : 32'hxxxx_xxxx;
        check("imem_addr", imem_addr, epc);
        check("valid_in_issue", {31'd0, inst_valid}, 32'd0);
`ifdef IFETCH_PERF_CNT_EN
        check("perf_fetched", perf_fetched, 32'(m_fetched));
        check("perf_stall_cycles", perf_stall_cycles, 32'(m_stalls));
`endif
        imem_rvalid = ($urandom_range(0, 3) == 0);
        imem_rdata  = $urandom;
        for (int j = 1; j <= lat; j++) begin
            @(negedge clock);
            check("req_in_wait", {31'd0, imem_req}, 32'd0);
            check("valid_in_wait", {31'd0, inst_valid}, 32'd0);
            imem_rvalid = (j == lat);
            imem_rdata  = (j == lat) ? word : $urandom;
        end
        @(negedge clock);
        imem_rvalid = 1'b0;
        check("inst_valid", {31'd0, inst_valid}, 32'd1);
        check("instruction", instruction, word);
        check("opcode", {26'd0, opcode}, {26'd0, word[31:26]});
        check("pc", pc, epc);
        check("pc_plus4", pc_plus4, epc + 32'd4);
        check("req_in_valid", {31'd0, imem_req}, 32'd0);
        for (int i = 1; i <= nstall; i++) begin
            stall = 1'b1;
            drive_garbage_ctrl();
            imem_rvalid = 1'($urandom_range(0, 1));
            imem_rdata  = $urandom;
            @(negedge clock);
            m_stalls++;
            check("stall_valid", {31'd0, inst_valid}, 32'd1);
            check("stall_no_req", {31'd0, imem_req}, 32'd0);
            check("stall_instr", instruction, word);
            check("stall_pc", pc, epc);
            check("stall_pc_plus4", pc_plus4, epc + 32'd4);
        end
        stall         = 1'b0;
        imem_rvalid   = 1'b0;
        branch        = br;
        zero          = zr;
        jump          = jp;
        branch_offset = off;
        if (jp)
            npc = ((epc + 32'd4) & 32'hF000_0000) | ((word & 32'h03FF_FFFF) << 2);
        else if (br && zr)
            npc = epc + 32'd4 + off * 32'd4;
        else
            npc = epc + 32'd4;
        exp_q.push_back(npc);
        m_fetched++;
        @(negedge clock);
        drive_garbage_ctrl();
        stall = 1'($urandom_range(0, 1));
    endtask

    task automatic reset_in_wait();
        wait_req();
        check("rst_test_addr", imem_addr, exp_q.size() > 0 ? exp_q.pop_front() : 32'hxxxx_xxxx);
        stall = 1'b0;
        for (int j = 1; j <= 2; j++) @(negedge clock);
        reset = 1'b1;
        #1;
        check("rst_async_valid", {31'd0, inst_valid}, 32'd0);
        check("rst_async_pc", pc, 32'h0000_0040);
        check("rst_async_pc_plus4", pc_plus4, 32'h0000_0044);
        check("rst_async_instr", instruction, 32'd0);
        check("rst_async_opcode", {26'd0, opcode}, 32'd0);
        check("rst_async_addr", imem_addr, 32'h0000_0040);
        @(negedge clock);
        imem_rvalid = 1'b1;
        imem_rdata  = 32'hDEAD_BEEF;
        @(negedge clock);
        imem_rvalid = 1'b0;
        reset       = 1'b0;
        exp_q.delete();
        exp_q.push_back(32'h0000_0040);
        m_fetched = 0;
        m_stalls  = 0;
    endtask

    initial begin
        logic [31:0] r;
        reset         = 1'b1;
        imem_rvalid   = 1'b0;
        imem_rdata    = 32'd0;
        stall         = 1'b0;
        branch        = 1'b0;
        zero          = 1'b0;
        jump          = 1'b0;
        branch_offset = 32'd0;
        exp_q.push_back(32'h0000_0040);
        repeat (2) @(negedge clock);
        check("reset_valid", {31'd0, inst_valid}, 32'd0);
        check("reset_pc", pc, 32'h0000_0040);
        check("reset_pc_plus4", pc_plus4, 32'h0000_0044);
        check("reset_instr", instruction, 32'd0);
        check("reset_opcode", {26'd0, opcode}, 32'd0);
        reset = 1'b0;

        // Sequential, branch taken / not taken, far branch with stall, jump+branch
        fetch_one(1, 32'h2008_0001, 0, 1'b0, 1'b0, 1'b0, 32'd0);
        fetch_one(1, 32'h8C09_0004, 0, 1'b0, 1'b0, 1'b0, 32'd0);
        fetch_one(1, 32'h1109_FFFE, 0, 1'b1, 1'b1, 1'b0, 32'hFFFF_FFFE);
        fetch_one(2, 32'h1109_FFFE, 0, 1'b1, 1'b0, 1'b0, 32'hFFFF_FFFE);
        fetch_one(1, 32'h1000_0001, 5, 1'b1, 1'b1, 1'b0, 32'h03FF_FFF1);
        fetch_one(1, 32'h0800_0100, 0, 1'b1, 1'b1, 1'b1, 32'h0000_0005);
        fetch_one(3, 32'h0000_0020, 0, 1'b0, 1'b0, 1'b0, 32'd0);

        reset_in_wait();
        fetch_one(1, 32'hAC0A_0008, 0, 1'b0, 1'b0, 1'b0, 32'd0);

        for (int n = 0; n < 150; n++) begin
            r = $urandom;
            fetch_one($urandom_range(1, 4), $urandom,
                      ($urandom_range(0, 2) == 0) ? $urandom_range(1, 4) : 0,
                      1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                      ($urandom_range(0, 3) == 0),
                      {{16{r[15]}}, r[15:0]});
        end
        wait_req();
        check("final_addr", imem_addr, exp_q.size() > 0 ? exp_q.pop_front() : 32'hxxxx_xxxx);
`ifdef IFETCH_PERF_CNT_EN
        check("final_perf_fetched", perf_fetched, 32'(m_fetched));
        check("final_perf_stalls", perf_stall_cycles, 32'(m_stalls));
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/ifetch_unit.md
Name: ifetch_unit

Overview:
Instruction fetch stage for the single-issue MIPS-subset core. Holds the PC, issues one word request per instruction to instruction memory, captures the returned word, and presents it to decode. The control/decode stage reads the opcode from here. Next-PC selection (sequential, beq taken, j/jal) happens when decode consumes an instruction. There is no prefetch and no speculation, so no flush path is needed.

Parameters:
RESET_PC, 32'h0000_0000, PC value loaded on reset; first fetch address.
ADDR_W, 32, PC/address width; fixed at 32 for this core.

Ports:
clock  in  1  core clock; all state changes on its rising edge
reset  in  1  asynchronous, active-high reset
imem_req  out  1  one-cycle request strobe to instruction memory
imem_addr  out  32  word-aligned fetch address; valid while imem_req=1
imem_rvalid  in  1  read data valid from instruction memory; latency >=1 cycle
imem_rdata  in  32  instruction word returned with imem_rvalid
stall  in  1  decode/hazard hold; the held instruction is not consumed
branch  in  1  from control: current instruction is beq
zero  in  1  ALU zero flag for the current instruction
branch_offset  in  32  sign-extended 16-bit immediate of the current instruction
jump  in  1  from control: current instruction is j or jal
inst_valid  out  1  instruction/pc/pc_plus4 outputs are valid
instruction  out  32  captured instruction word
opcode  out  6  instruction[31:26]; feeds the control unit
pc  out  32  address of the presented instruction
pc_plus4  out  32  pc+4; used for the jal link value

Behaviour:
- States: ISSUE, WAIT, VALID. State, pc, and instruction are registers. imem_req, imem_addr, and inst_valid are decoded from the state.
- Reset (asynchronous, any state): state=ISSUE, pc=RESET_PC, instruction=0, inst_valid=0. Outputs follow: imem_req=1 and imem_addr=RESET_PC in the first cycle after reset deasserts, opcode=0, pc_plus4=RESET_PC+4.
- ISSUE: imem_req=1, imem_addr=pc, for exactly one cycle. Next state is WAIT.
- WAIT: imem_req=0. On imem_rvalid, capture instruction<=imem_rdata and go to VALID. Otherwise stay in WAIT indefinitely; there is no timeout.
- VALID: inst_valid=1.
  - Fire = inst_valid & ~stall.
  - On fire: pc<=next_pc, state<=ISSUE.
  - While stalled: instruction, pc, and pc_plus4 are held bit-stable.
- Latency: ISSUE at cycle t, rvalid at t+k (k>=1), inst_valid at t+k+1. Minimum 3 cycles per instruction.
- next_pc (evaluated only on fire), in priority order:
  1. jump=1: {pc_plus4[31:28], instruction[25:0], 2'b00}.
  2. branch=1 and zero=1: pc_plus4 + (branch_offset<<2).
  3. Otherwise: pc_plus4.
- branch, zero, jump, and branch_offset are ignored when there is no fire.
- Arithmetic is 32-bit modulo; wrap-around of the PC is legal and silent. Low two bits of imem_addr are always 00 by construction.
- imem_rvalid in ISSUE or VALID is a protocol violation and is ignored; instruction is not overwritten.
- Simultaneous jump=1 and branch=1: jump wins.
- Reset asserted in WAIT: the outstanding response is abandoned. Instruction memory shares the same reset and drops in-flight reads.

Optional Feature:
Macro IFETCH_PERF_CNT_EN.
- Defined: adds outputs perf_fetched (32) and perf_stall_cycles (32).
  - perf_fetched increments on every fire.
  - perf_stall_cycles increments every cycle that VALID and stall are both 1.
  - Both reset to 0 and wrap modulo 2^32.
- Undefined: ports and counters are absent; all other behaviour is identical.

Test Plan:
- Reset with RESET_PC=0x0000_0040, memory latency 1 -> imem_req with addr 0x40 in the first cycle after reset drops; inst_valid two cycles later; pc=0x40, pc_plus4=0x44.
- Sequential fetch, stall=0, no branch/jump -> imem_addr sequence 0x40, 0x44, 0x48, one request every 3 cycles; opcode equals rdata[31:26].
- beq taken (branch=1, zero=1, branch_offset=0xFFFF_FFFE) at pc=0x48 -> next imem_addr = 0x4C-8 = 0x44. Same case with zero=0 -> 0x4C.
- j with instruction[25:0]=0x000_0100 at pc=0x1000_0010 -> next imem_addr 0x1000_0400. jump and branch both 1 -> jump target used.
- stall held 5 cycles in VALID -> inst_valid=1, outputs stable, no imem_req. After release, one fire and one request. With IFETCH_PERF_CNT_EN, perf_stall_cycles=5.
- Reset asserted in WAIT with memory latency 4 -> all outputs return to reset values immediately. After release the fetch restarts at RESET_PC, and no stale word is captured.
